credit_sender: RTL and testbench
================================

Name: credit_sender

Overview:
- Upstream peer of the credit receiver: accepts data from a local ready/valid source and forwards it over a credit-based link only when a credit is held.
- Holds the sender-side credit counter.
  - Consumes one credit per transfer.
  - Regains one credit for each credit returned by the receiver.
- Exchanges in-reset indications with the receiver so that neither side transmits across a reset boundary.

Parameters:
- Width, 8, data payload width in bits.
- MaxCredit, 1, maximum credits the counter can hold; must be >= 1.
- CountWidth, $clog2(MaxCredit+1), width of all credit count/initial/withhold ports (derived, not overridable).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; state resets when rst==0 at a rising edge.
- push_valid  input  1  local source has data.
- push_ready  output  1  transfer accepted this cycle when push_valid&push_ready.
- push_data  input  Width  local payload.
- pop_sender_in_reset  output  1  tells receiver this sender is in reset.
- pop_receiver_in_reset  input  1  receiver is in reset.
- pop_credit  input  1  one credit returned by receiver this cycle.
- pop_valid  output  1  link valid, one beat per consumed credit.
- pop_data  output  Width  link payload.
- credit_initial  input  CountWidth  count loaded on reset and while receiver is in reset; must be <= MaxCredit and stable while rst==0.
- credit_withhold  input  CountWidth  credits reserved and never spent; may change at any time.
- credit_count  output  CountWidth  current registered credit count.
- credit_available  output  CountWidth  credit_count minus credit_withhold, floored at 0.
- credit_overflow  output  1  sticky error flag.

Behaviour:
- pop_sender_in_reset = ~rst (combinational).
- Reset (rst==0 at edge), all state registered:
  - credit_count <= credit_initial
  - pop_valid <= 0
  - pop_data <= 0
  - credit_overflow <= 0
- Receiver in reset (pop_receiver_in_reset==1, rst==1):
  - credit_count <= credit_initial
  - pop_credit ignored
  - push_ready = 0
  - pop_valid <= 0
  - credit_overflow holds its value.
- credit_available = (credit_count > credit_withhold) ? credit_count - credit_withhold : 0. Combinational.
- push_ready = (credit_available != 0) & rst & ~pop_receiver_in_reset. Combinational.
  - No dependence on push_valid.
- send = push_valid & push_ready.
- Output register:
  - pop_valid <= send.
  - pop_data <= push_data when send, else hold.
  - Latency one cycle from accept to link beat; no backpressure on the link.
- Counter update (normal operation): next = credit_count - send + pop_credit.
  - send and pop_credit in the same cycle leave the count unchanged.
  - pop_credit with credit_count == MaxCredit and no send: count holds at MaxCredit and credit_overflow <= 1. This is a protocol error and the flag stays set until reset.
  - Underflow is impossible because send requires credit_available >= 1.
- Returned credit usage:
  - A credit returned in cycle N can enable push_ready in cycle N+1, not N.
  - There is no combinational path from pop_credit to push_ready.
- credit_withhold rules:
  - Raising credit_withhold above credit_count blocks sends immediately (same cycle).
  - Credits already spent are not reclaimed.
- Reset mid-operation:
  - An in-flight pop_valid beat is dropped (pop_valid low the next cycle).
  - The count reloads to credit_initial regardless of outstanding credits.
- Sizing: all arithmetic is in CountWidth+1 bits internally, with no wrap-around.

Test Plan:
- Reset load: MaxCredit=4, credit_initial=3, rst low 2 cycles then high.
  - Required: credit_count=3, credit_available=3, pop_valid=0, pop_sender_in_reset 1 during reset and 0 after.
- Credit exhaustion: initial=2, push_valid held high, data 0xA1,0xA2,0xA3.
  - Required: two accepts; pop_valid/pop_data show 0xA1 then 0xA2 one cycle after each accept.
  - Required: push_ready=0 with credit_count=0; 0xA3 is held.
- Credit return: continue the exhaustion case; pulse pop_credit in cycle N.
  - Required: push_ready=1 in N+1; 0xA3 appears on pop_data in N+2; credit_count ends at 0.
- Simultaneous send and return: count=1, push_valid=1 and pop_credit=1 in the same cycle.
  - Required: count stays 1 and a beat is emitted.
  - With count=0, pop_credit and push_valid the same cycle: no send that cycle, count becomes 1.
- Withhold and overflow: MaxCredit=4, count=4, credit_withhold=4.
  - Required: push_ready=0 and credit_available=0.
  - Then pop_credit with no send: count stays 4 and credit_overflow=1, and it remains 1 until rst.
- Receiver reset: mid-stream, assert pop_receiver_in_reset for 3 cycles with pop_credit pulsing.
  - Required: push_ready=0 and pop_valid=0 for those cycles.
  - Required: count=credit_initial on release, and the pulses are ignored.

Source files
------------

// File: rtl/credit_sender.sv
// rtl/credit_sender.sv - credit-gated ready/valid to credit-link sender with registered link output
module credit_sender #(
    parameter int Width = 8,
    parameter int MaxCredit = 1,
    localparam int CountWidth = $clog2(MaxCredit + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [Width-1:0]      push_data,
    output logic                  pop_sender_in_reset,
    input  logic                  pop_receiver_in_reset,
    input  logic                  pop_credit,
    output logic                  pop_valid,
    output logic [Width-1:0]      pop_data,
    input  logic [CountWidth-1:0] credit_initial,
    input  logic [CountWidth-1:0] credit_withhold,
    output logic [CountWidth-1:0] credit_count,
    output logic [CountWidth-1:0] credit_available,
    output logic                  credit_overflow
);

    localparam logic [CountWidth:0] MaxCountExt = (CountWidth + 1)'(MaxCredit);

    logic [CountWidth-1:0] count_q;
    logic [CountWidth:0]   count_ext;
    logic [CountWidth:0]   withhold_ext;
    logic [CountWidth:0]   avail_ext;
    logic [CountWidth:0]   next_ext;
    logic                  send;
    logic                  overflow_now;

    assign pop_sender_in_reset = ~rst;
    assign credit_count        = count_q;

    // One extra bit of headroom so the return path can exceed MaxCredit without wrapping.
    assign count_ext    = {1'b0, count_q};
    assign withhold_ext = {1'b0, credit_withhold};

    always_comb begin
        avail_ext = '0;
        if (count_ext > withhold_ext) begin
            avail_ext = count_ext - withhold_ext;
        end
    end

    assign credit_available = avail_ext[CountWidth-1:0];

    // Readiness depends only on registered count and withhold, never on pop_credit.
    assign push_ready = (avail_ext != '0) & rst & ~pop_receiver_in_reset;
    assign send       = push_valid & push_ready;

    always_comb begin
        next_ext = count_ext - {{CountWidth{1'b0}}, send} + {{CountWidth{1'b0}}, pop_credit};
    end

    assign overflow_now = (next_ext > MaxCountExt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q         <= credit_initial;
            pop_valid       <= 1'b0;
            pop_data        <= '0;
            credit_overflow <= 1'b0;
        end else if (pop_receiver_in_reset) begin
            count_q   <= credit_initial;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= send;
            if (send) begin
                pop_data <= push_data;
            end
            if (overflow_now) begin
                count_q         <= MaxCountExt[CountWidth-1:0];
                credit_overflow <= 1'b1;
            end else begin
                count_q <= next_ext[CountWidth-1:0];
            end
        end
    end

endmodule

// File: tb/tb_credit_sender.sv
// tb/tb_credit_sender.sv - randomized and directed checks of credit_sender against a credit model
module tb_credit_sender;

    localparam int W  = 8;
    localparam int MC = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [W-1:0]  push_data;
    logic          pop_sender_in_reset;
    logic          pop_receiver_in_reset;
    logic          pop_credit;
    logic          pop_valid;
    logic [W-1:0]  pop_data;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic [CW-1:0] credit_available;
    logic          credit_overflow;

    int checks   = 0;
    int failures = 0;

    credit_sender #(.Width(W), .MaxCredit(MC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .push_valid            (push_valid),
        .push_ready            (push_ready),
        .push_data             (push_data),
        .pop_sender_in_reset   (pop_sender_in_reset),
        .pop_receiver_in_reset (pop_receiver_in_reset),
        .pop_credit            (pop_credit),
        .pop_valid             (pop_valid),
        .pop_data              (pop_data),
        .credit_initial        (credit_initial),
        .credit_withhold       (credit_withhold),
        .credit_count          (credit_count),
        .credit_available      (credit_available),
        .credit_overflow       (credit_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Credit model: an integer pool, a sticky error bit and the last accepted beat.
    int       m_count;
    bit       m_ovf;
    bit       m_pv;
    bit [W-1:0] m_pd;
    bit       m_live = 1'b0;

    always @(posedge clk) begin
        int av;
        int nc;
        bit s;
        av = (m_count > int'(credit_withhold)) ? m_count - int'(credit_withhold) : 0;
        if (!rst) begin
            m_count <= int'(credit_initial);
            m_pv    <= 1'b0;
            m_pd    <= '0;
            m_ovf   <= 1'b0;
            m_live  <= 1'b1;
        end else if (pop_receiver_in_reset) begin
            m_count <= int'(credit_initial);
            m_pv    <= 1'b0;
        end else begin
            s  = push_valid && (av > 0);
            nc = m_count - (s ? 1 : 0) + (pop_credit ? 1 : 0);
            m_pv <= s;
            if (s) m_pd <= push_data;
            if (nc > MC) begin
                m_count <= MC;
                m_ovf   <= 1'b1;
            end else begin
                m_count <= nc;
            end
        end
    end

    always @(negedge clk) begin
        int av;
        bit rdy;
        chk("sender_in_reset", pop_sender_in_reset, !rst);
        if (m_live) begin
            av  = (m_count > int'(credit_withhold)) ? m_count - int'(credit_withhold) : 0;
            rdy = (av != 0) && rst && !pop_receiver_in_reset;
            chk("model_count", credit_count, m_count);
            chk("model_available", credit_available, av);
            chk("model_push_ready", push_ready, rdy);
            chk("model_pop_valid", pop_valid, m_pv);
            chk("model_pop_data", pop_data, m_pd);
            chk("model_overflow", credit_overflow, m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        push_valid = 1'b0;
        push_data = '0;
        pop_receiver_in_reset = 1'b0;
        pop_credit = 1'b0;
        credit_initial = 3'd3;
        credit_withhold = '0;

        // Reset load
        tick();
        look();
        chk("lit_in_reset_high", pop_sender_in_reset, 1);
        tick();
        rst = 1'b1;
        look();
        chk("lit_reset_count", credit_count, 3);
        chk("lit_reset_avail", credit_available, 3);
        chk("lit_reset_pv", pop_valid, 0);
        chk("lit_in_reset_low", pop_sender_in_reset, 0);

        // Credit exhaustion then return
        tick();
        rst = 1'b0;
        credit_initial = 3'd2;
        tick();
        rst = 1'b1;
        push_valid = 1'b1;
        push_data = 8'hA1;
        look();
        chk("lit_exh_ready0", push_ready, 1);
        tick();
        push_data = 8'hA2;
        look();
        chk("lit_exh_pv_a1", pop_valid, 1);
        chk("lit_exh_pd_a1", pop_data, 8'hA1);
        tick();
        push_data = 8'hA3;
        look();
        chk("lit_exh_pd_a2", pop_data, 8'hA2);
        chk("lit_exh_ready_blocked", push_ready, 0);
        chk("lit_exh_count0", credit_count, 0);
        tick();
        look();
        chk("lit_exh_a3_held", pop_valid, 0);
        tick();
        pop_credit = 1'b1;
        look();
        chk("lit_ret_ready_n", push_ready, 0);
        tick();
        pop_credit = 1'b0;
        look();
        chk("lit_ret_ready_n1", push_ready, 1);
        tick();
        push_valid = 1'b0;
        look();
        chk("lit_ret_pv_n2", pop_valid, 1);
        chk("lit_ret_pd_a3", pop_data, 8'hA3);
        chk("lit_ret_count", credit_count, 0);

        // Simultaneous send and return
        tick();
        push_valid = 1'b1;
        pop_credit = 1'b1;
        look();
        chk("lit_sim0_ready", push_ready, 0);
        tick();
        look();
        chk("lit_sim0_pv", pop_valid, 0);
        chk("lit_sim0_count", credit_count, 1);
        tick();
        push_valid = 1'b0;
        pop_credit = 1'b0;
        look();
        chk("lit_sim1_count", credit_count, 1);
        chk("lit_sim1_pv", pop_valid, 1);

        // Withhold and overflow
        tick();
        rst = 1'b0;
        credit_initial = 3'd4;
        tick();
        rst = 1'b1;
        credit_withhold = 3'd4;
        look();
        chk("lit_wh_count", credit_count, 4);
        chk("lit_wh_ready", push_ready, 0);
        chk("lit_wh_avail", credit_available, 0);
        tick();
        pop_credit = 1'b1;
        tick();
        pop_credit = 1'b0;
        look();
        chk("lit_ovf_count", credit_count, 4);
        chk("lit_ovf_flag", credit_overflow, 1);
        tick();
        tick();
        look();
        chk("lit_ovf_sticky", credit_overflow, 1);

        // Receiver reset mid-stream
        tick();
        credit_withhold = '0;
        push_valid = 1'b1;
        push_data = 8'($urandom);
        tick();
        push_data = 8'($urandom);
        tick();
        for (int i = 0; i < 3; i++) begin
            pop_receiver_in_reset = 1'b1;
            pop_credit = (i != 1);
            push_data = 8'($urandom);
            look();
            chk("lit_rir_ready", push_ready, 0);
            if (i > 0) chk("lit_rir_pv", pop_valid, 0);
            tick();
        end
        pop_receiver_in_reset = 1'b0;
        pop_credit = 1'b0;
        push_valid = 1'b0;
        look();
        chk("lit_rir_count", credit_count, 4);
        chk("lit_rir_pv_after", pop_valid, 0);
        chk("lit_rir_ovf_held", credit_overflow, 1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        look();
        chk("lit_ovf_cleared", credit_overflow, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 199) != 0);
            if (rst && $urandom_range(0, 49) == 0) credit_initial = CW'($urandom_range(0, MC));
            pop_receiver_in_reset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) credit_withhold = CW'($urandom_range(0, MC));
            else if ($urandom_range(0, 29) == 0) credit_withhold = '0;
            push_valid = ($urandom_range(0, 3) != 0);
            push_data  = 8'($urandom);
            pop_credit = ($urandom_range(0, 2) == 0);
        end
        tick();
        look();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
